uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

UART receiver with a small show-ahead receive FIFO, the receive half of the core's serial link (counterpart of the transmit path). It oversamples the asynchronous `rxd` pin using the shared `clock_enable` tick, deframes 8N1 characters LSB-first, and buffers completed bytes. The CPU datapath pops bytes through a valid/read handshake and polls sticky error flags.

## Interface
- `CLKS_PER_BIT`, 8: `ce` ticks per bit period. Must be an even value of at least 4.
- `FIFO_DEPTH`, 4: number of buffered bytes. Must be a power of two of at least 2.
- `cpu_clock`  in  1  system clock. All logic is on its rising edge.
- `reset_n`  in  1  reset, synchronous, active-low; clock cpu_clock.
- `ce`  in  1  baud oversample tick. One cycle high per sample slot.
- `i_rx`  in  1  asynchronous serial input. Idle level is high.
- `i_read`  in  1  pop the head byte. Ignored when `o_valid`=0.
- `i_clear_err`  in  1  clear all sticky error flags.
- `o_data`  out  8  FIFO head byte. Meaningful only while `o_valid`=1.
- `o_valid`  out  1  FIFO not empty.
- `o_count`  out  $clog2(FIFO_DEPTH+1)  number of bytes held.
- `o_busy`  out  1  receiver is in any state other than IDLE.
- `o_frame_err`  out  1  sticky flag: a character had stop bit = 0.
- `o_overrun`  out  1  sticky flag: a byte was dropped because the FIFO was full.
- `o_parity_err`  out  1  sticky flag: parity mismatch. Constant 0 without the macro.

## Operation
- `i_rx` passes through a 2-flop synchronizer clocked every `cpu_clock` cycle, independent of `ce`. The result is `rx_s`.
- Tick counter `tcnt` and bit index `bidx` advance only on cycles with `ce`=1.
- **IDLE**: on a `ce` tick with `rx_s`=0, go to START and set `tcnt`=0.
- **START**: at `tcnt`=CLKS_PER_BIT/2-1, resample `rx_s`.
  - If `rx_s`=1, this is a false start: return to IDLE.
  - If `rx_s`=0, go to DATA with `tcnt`=0 and `bidx`=0.
- **DATA**: each time `tcnt` reaches CLKS_PER_BIT-1, shift `rx_s` into bit `bidx` (LSB first) and reset `tcnt` to 0.
  - After bit 7, go to PARITY if the macro is defined, otherwise go to STOP.
- **PARITY** (macro only): sample the parity bit mid-bit, then go to STOP.
- **STOP**: sample `rx_s` mid-bit.
  - If it is 1 and parity is good (or the macro is absent), push the byte and go to IDLE.
  - If it is 0, set `o_frame_err`, discard the byte, and go to BREAK.
- **BREAK**: wait for a `ce` tick with `rx_s`=1, then go to IDLE. This prevents a held-low line from re-arming the receiver.
- FIFO: circular buffer with read/write pointers and a count.
  - `o_data` = mem[rd_ptr], `o_valid` = (count != 0).
  - Pointers wrap modulo FIFO_DEPTH.
  - Pop happens when `i_read`=1 and count>0.
- Push while full: the byte is dropped, `o_overrun` is set, and FIFO contents are unchanged.
- Push and pop in the same cycle:
  - If count>0, both succeed and count is unchanged. This holds even when full, with no overrun.
  - If count=0, only the push happens.
- `i_clear_err`=1 clears all sticky flags. If an error is set in the same cycle as a clear, the set wins.

## Timing
- Reset values: `o_valid`=0, `o_count`=0, `o_data`=0 (memory zeroed), `o_busy`=0, all error flags 0, state IDLE, synchronizer flops 1.
- Reset asserted mid-frame: the partial character is discarded and the FIFO is emptied. After release, the receiver requires a fresh falling edge on `rx_s`.
- Push latency: the byte is written on the `cpu_clock` edge of the stop-sample `ce` cycle. `o_valid`/`o_count`/`o_data` update on the following cycle.
- Pop: after an edge with `i_read`=1, `o_data` shows the next entry and `o_count` decrements.
- Input latency: 2 `cpu_clock` cycles of synchronizer, plus up to 1 `ce` period of start-detect jitter.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Frames are 8E1, with an even-parity bit between data bit 7 and the stop bit.
  - A mismatch sets `o_parity_err` and discards the byte.
  - The stop bit is still checked.
- Not defined:
  - Frames are 8N1 and the PARITY state is absent.
  - `o_parity_err` is tied to 0; the port remains so the interface is the same in both builds.

## Test plan
- Frame 0x55 at CLKS_PER_BIT=8, `ce` every 4 clocks -> `o_valid`=1, `o_data`=0x55, `o_count`=1; `i_read` pulse -> `o_valid`=0.
- Low glitch of 2 `ce` ticks on idle line -> returns to IDLE, `o_valid` stays 0, no error flags set.
- Frame 0xA3 with stop bit 0, line held low for 20 bit times -> `o_frame_err`=1, nothing pushed, `o_busy`=1 until line goes high; next frame 0x3C is received correctly.
- Frames 0x01..0x05 with no reads -> `o_count`=4, pops return 0x01..0x04, `o_overrun`=1; `i_clear_err` -> 0.
- FIFO full, `i_read` asserted on the push cycle of 0x99 -> no overrun, `o_count` stays 4, 0x99 is read last.
- `reset_n` low mid-DATA and with 2 bytes buffered -> `o_count`=0, `o_busy`=0; the next clean frame 0x7E is received. With `UART_RX_PARITY_EN`: 0x07 with parity bit 0 -> `o_parity_err`=1, no push.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver (8N1, LSB first) feeding a show-ahead FIFO.
//
// Optional feature macro: UART_RX_PARITY_EN
//   - Defined: frames are 8E1, with an even-parity bit between data bit 7 and
//     the stop bit. A parity mismatch sets o_parity_err and drops the byte.
//   - Undefined: frames are 8N1 and o_parity_err is tied to 0.
//
// Ports:
//   cpu_clock    system clock, all logic on the rising edge
//   reset_n      synchronous active-low reset
//   ce           oversample tick, CLKS_PER_BIT ticks per bit period
//   i_rx         asynchronous serial input, idles high
//   i_read       pop the head byte (ignored while o_valid=0)
//   i_clear_err  clear all sticky error flags (a simultaneous set wins)
//   o_data       FIFO head byte (meaningful while o_valid=1)
//   o_valid      FIFO not empty
//   o_count      number of bytes held
//   o_busy       receiver not idle
//   o_frame_err  sticky: a stop bit sampled as 0
//   o_overrun    sticky: a byte was dropped because the FIFO was full
//   o_parity_err sticky: parity mismatch (constant 0 without the macro)
//
// Handshake: o_valid/i_read. The head byte is popped on any rising edge where
// o_valid=1 and i_read=1; o_data then shows the next entry on the next cycle.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                              cpu_clock,
  input  logic                              reset_n,
  input  logic                              ce,
  input  logic                              i_rx,
  input  logic                              i_read,
  input  logic                              i_clear_err,
  output logic [7:0]                        o_data,
  output logic                              o_valid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_count,
  output logic                              o_busy,
  output logic                              o_frame_err,
  output logic                              o_overrun,
  output logic                              o_parity_err
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
`ifdef UART_RX_PARITY_EN
    , ST_PARITY = 3'd5
`endif
  } state_t;

  logic            rx_meta_q, rx_s_q;
  state_t          state_q, state_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic [2:0]      bidx_q, bidx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [7:0]      mem_d [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;
  logic            stop_sample, push, frame_set, pop, full, wr_en, overrun_set;
`ifdef UART_RX_PARITY_EN
  logic            par_bad_q, par_bad_d;
  logic            parity_err_q, parity_err_d;
  logic            parity_set;
`endif

  // State register and all other flops.
  always_ff @(posedge cpu_clock) begin
    if (!reset_n) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= ST_IDLE;
      tcnt_q      <= '0;
      bidx_q      <= '0;
      shreg_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_meta_q   <= i_rx;
      rx_s_q      <= rx_meta_q;
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
      bidx_q      <= bidx_d;
      shreg_q     <= shreg_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // Next-state logic. Everything here only moves on ce ticks; after START
  // re-centres tcnt mid start bit, every T_LAST tick is the middle of a bit.
  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bidx_d  = bidx_q;
    shreg_d = shreg_q;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
`endif
    if (ce) begin
      case (state_q)
        ST_IDLE: begin
          if (!rx_s_q) begin
            state_d = ST_START;
            tcnt_d  = '0;
          end
        end
        ST_START: begin
          if (tcnt_q == T_HALF) begin
            tcnt_d = '0;
            bidx_d = '0;
            state_d = rx_s_q ? ST_IDLE : ST_DATA;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
        ST_DATA: begin
          if (tcnt_q == T_LAST) begin
            shreg_d[bidx_q] = rx_s_q;
            tcnt_d = '0;
            bidx_d = bidx_q + 3'd1;
            if (bidx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (tcnt_q == T_LAST) begin
            // Even parity: data bits plus parity bit must XOR to 0.
            par_bad_d = rx_s_q ^ (^shreg_q);
            tcnt_d    = '0;
            state_d   = ST_STOP;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
`endif
        ST_STOP: begin
          if (tcnt_q == T_LAST) begin
            tcnt_d  = '0;
            state_d = rx_s_q ? ST_IDLE : ST_BREAK;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
        ST_BREAK: begin
          // Hold here until the line returns high so a stuck-low line
          // cannot retrigger a start.
          if (rx_s_q) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs.
  always_comb begin
    stop_sample = ce && (state_q == ST_STOP) && (tcnt_q == T_LAST);
    frame_set   = stop_sample && !rx_s_q;
`ifdef UART_RX_PARITY_EN
    push        = stop_sample && rx_s_q && !par_bad_q;
    parity_set  = stop_sample && rx_s_q && par_bad_q;
`else
    push        = stop_sample && rx_s_q;
`endif
    o_busy      = (state_q != ST_IDLE);
  end

  // FIFO and sticky flags. A pop frees the slot in the same edge, so a push
  // into a full FIFO still succeeds when it coincides with a pop.
  always_comb begin
    pop         = i_read && (count_q != '0);
    full        = (count_q == C_FULL);
    wr_en       = push && (!full || pop);
    overrun_set = push && full && !pop;
    mem_d       = mem_q;
    if (wr_en) mem_d[wr_ptr_q] = shreg_q;
    wr_ptr_d    = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    frame_err_d = frame_set   || (frame_err_q && !i_clear_err);
    overrun_d   = overrun_set || (overrun_q && !i_clear_err);
`ifdef UART_RX_PARITY_EN
    parity_err_d = parity_set || (parity_err_q && !i_clear_err);
`endif
  end

  assign o_data      = mem_q[rd_ptr_q];
  assign o_valid     = (count_q != '0);
  assign o_count     = count_q;
  assign o_frame_err = frame_err_q;
  assign o_overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign o_parity_err = parity_err_q;
`else
  assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed bench for uart_rx_fifo at CLKS_PER_BIT=8 with
// ce every 4 clocks, so one bit period is 32 cpu_clock cycles.
module tb_uart_rx_fifo;

  localparam int BIT_CLKS = 32;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS  = 11;
  localparam int PUSH_K = 340;
`else
  localparam int NBITS  = 10;
  localparam int PUSH_K = 308;
`endif

  logic       cpu_clock;
  logic       reset_n;
  logic       ce;
  logic       i_rx;
  logic       i_read;
  logic       i_clear_err;
  logic [7:0] o_data;
  logic       o_valid;
  logic [2:0] o_count;
  logic       o_busy;
  logic       o_frame_err;
  logic       o_overrun;
  logic       o_parity_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  uart_rx_fifo #(.CLKS_PER_BIT(8), .FIFO_DEPTH(4)) dut (
    .cpu_clock    (cpu_clock),
    .reset_n      (reset_n),
    .ce           (ce),
    .i_rx         (i_rx),
    .i_read       (i_read),
    .i_clear_err  (i_clear_err),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .o_count      (o_count),
    .o_busy       (o_busy),
    .o_frame_err  (o_frame_err),
    .o_overrun    (o_overrun),
    .o_parity_err (o_parity_err)
  );

  // Clock / reset block and ce generator.
  initial begin
    cpu_clock = 1'b0;
    forever #5 cpu_clock = ~cpu_clock;
  end

  always @(posedge cpu_clock) cyc <= cyc + 1;

  // ce is high for every edge whose preceding negedge sees cyc%4==0.
  initial begin
    ce = 1'b0;
    forever begin
      @(negedge cpu_clock);
      ce = ((cyc % 4) == 0);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge cpu_clock);
  endtask

  task automatic pop_byte();
    i_read = 1'b1;
    @(negedge cpu_clock);
    i_read = 1'b0;
  endtask

  task automatic clear_err();
    i_clear_err = 1'b1;
    @(negedge cpu_clock);
    i_clear_err = 1'b0;
  endtask

  // Drive one frame aligned to a ce phase. rd_k: cycle index at which i_read
  // is pulsed (-1 for none). max_k: stop driving after this many cycles.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input logic par_flip, input int rd_k, input int max_k);
    logic [10:0] bits;
    bits = 11'h7ff;
    bits[0] = 1'b0;
    bits[8:1] = b;
`ifdef UART_RX_PARITY_EN
    bits[9]  = (^b) ^ par_flip;
    bits[10] = stop_bit;
`else
    bits[9]  = stop_bit;
    bits[10] = par_flip | 1'b1;
`endif
    @(negedge cpu_clock);
    while ((cyc % 4) != 0) @(negedge cpu_clock);
    for (int k = 0; k < NBITS * BIT_CLKS; k++) begin
      if (k == max_k) break;
      i_rx   = bits[k / BIT_CLKS];
      i_read = (k == rd_k);
      @(negedge cpu_clock);
    end
    i_read = 1'b0;
  endtask

  task automatic send_ok(input logic [7:0] b);
    send_frame(b, 1'b1, 1'b0, -1, 100000);
    idle(4);
  endtask

  initial begin
    reset_n     = 1'b0;
    i_rx        = 1'b1;
    i_read      = 1'b0;
    i_clear_err = 1'b0;
    idle(5);
    check_eq("rst_valid", {31'd0, o_valid}, 32'd0);
    check_eq("rst_count", {29'd0, o_count}, 32'd0);
    check_eq("rst_data", {24'd0, o_data}, 32'd0);
    check_eq("rst_busy", {31'd0, o_busy}, 32'd0);
    check_eq("rst_flags", {29'd0, o_frame_err, o_overrun, o_parity_err}, 32'd0);
    reset_n = 1'b1;
    idle(10);

    // Basic frame.
    send_ok(8'h55);
    check_eq("f55_valid", {31'd0, o_valid}, 32'd1);
    check_eq("f55_data", {24'd0, o_data}, 32'h55);
    check_eq("f55_count", {29'd0, o_count}, 32'd1);
    pop_byte();
    check_eq("f55_pop_valid", {31'd0, o_valid}, 32'd0);

    // Short low glitch: false start.
    i_rx = 1'b0;
    idle(8);
    i_rx = 1'b1;
    idle(40);
    check_eq("glitch_busy", {31'd0, o_busy}, 32'd0);
    check_eq("glitch_valid", {31'd0, o_valid}, 32'd0);
    check_eq("glitch_flags", {29'd0, o_frame_err, o_overrun, o_parity_err}, 32'd0);

    // Framing error followed by a held-low line.
    send_frame(8'hA3, 1'b0, 1'b0, -1, 100000);
    i_rx = 1'b0;
    idle(20 * BIT_CLKS);
    check_eq("ferr_flag", {31'd0, o_frame_err}, 32'd1);
    check_eq("ferr_busy", {31'd0, o_busy}, 32'd1);
    check_eq("ferr_valid", {31'd0, o_valid}, 32'd0);
    i_rx = 1'b1;
    idle(20);
    check_eq("ferr_release_busy", {31'd0, o_busy}, 32'd0);
    send_ok(8'h3C);
    check_eq("f3c_data", {24'd0, o_data}, 32'h3C);
    check_eq("f3c_count", {29'd0, o_count}, 32'd1);
    pop_byte();
    clear_err();
    check_eq("ferr_cleared", {31'd0, o_frame_err}, 32'd0);

    // Overrun: five frames into a four-deep FIFO.
    for (int i = 1; i <= 5; i++) send_ok(8'(i));
    check_eq("ovr_count", {29'd0, o_count}, 32'd4);
    check_eq("ovr_flag", {31'd0, o_overrun}, 32'd1);
    for (int i = 1; i <= 4; i++) begin
      check_eq("ovr_pop_data", {24'd0, o_data}, 32'(i));
      pop_byte();
    end
    check_eq("ovr_empty", {29'd0, o_count}, 32'd0);
    clear_err();
    check_eq("ovr_cleared", {31'd0, o_overrun}, 32'd0);

    // Full FIFO with a pop on the push edge of 0x99.
    for (int i = 0; i < 4; i++) send_ok(8'h10 + 8'(i));
    send_frame(8'h99, 1'b1, 1'b0, PUSH_K, 100000);
    idle(4);
    check_eq("full_rw_count", {29'd0, o_count}, 32'd4);
    check_eq("full_rw_overrun", {31'd0, o_overrun}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      check_eq("full_rw_data", {24'd0, o_data}, 32'h11 + 32'(i));
      pop_byte();
    end
    check_eq("full_rw_last", {24'd0, o_data}, 32'h99);
    pop_byte();
    check_eq("full_rw_empty", {31'd0, o_valid}, 32'd0);

    // Reset mid-DATA with two bytes buffered.
    send_ok(8'h21);
    send_ok(8'h22);
    check_eq("pre_rst_count", {29'd0, o_count}, 32'd2);
    send_frame(8'h40, 1'b1, 1'b0, -1, 150);
    check_eq("mid_data_busy", {31'd0, o_busy}, 32'd1);
    reset_n = 1'b0;
    i_rx    = 1'b1;
    idle(3);
    check_eq("mid_rst_count", {29'd0, o_count}, 32'd0);
    check_eq("mid_rst_busy", {31'd0, o_busy}, 32'd0);
    check_eq("mid_rst_data", {24'd0, o_data}, 32'd0);
    reset_n = 1'b1;
    idle(10);
    send_ok(8'h7E);
    check_eq("f7e_data", {24'd0, o_data}, 32'h7E);
    check_eq("f7e_count", {29'd0, o_count}, 32'd1);
    pop_byte();

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones: even parity bit should be 1, send 0.
    send_frame(8'h07, 1'b1, 1'b1, -1, 100000);
    idle(4);
    check_eq("par_err", {31'd0, o_parity_err}, 32'd1);
    check_eq("par_nopush", {31'd0, o_valid}, 32'd0);
    check_eq("par_no_ferr", {31'd0, o_frame_err}, 32'd0);
    clear_err();
    check_eq("par_cleared", {31'd0, o_parity_err}, 32'd0);
`else
    check_eq("par_tied_low", {31'd0, o_parity_err}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
